// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one block memory port among NUM_REQ caches
// Optional transaction watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int BLK_W   = 128,
  parameter int TIMEOUT = 255,
  localparam int GW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_cs,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*BLK_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [BLK_W-1:0]          req_rdata,
  output logic                      mem_cs,
  output logic                      mem_rw,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [BLK_W-1:0]          mem_data,
  input  logic                      mem_ack,
  input  logic [BLK_W-1:0]          mem_rdata,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t        r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last;
  logic [GW-1:0] w_winner;
  logic          w_found;
  logic          w_busy;

  assign w_busy    = (r_state == ST_BUSY);
  assign busy      = w_busy;
  assign grant_id  = r_grant;
  assign req_rdata = mem_rdata;

  // Round-robin scan starting just after the previous owner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && req_cs[(int'(r_last) + i) % NUM_REQ]) begin
        w_found  = 1'b1;
        w_winner = GW'((int'(r_last) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    mem_cs   = 1'b0;
    mem_rw   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    req_ack  = '0;
    if (w_busy) begin
      mem_cs           = req_cs[r_grant];
      mem_rw           = req_rw[r_grant];
      mem_addr         = req_addr[r_grant*ADDR_W +: ADDR_W];
      mem_data         = req_data[r_grant*BLK_W +: BLK_W];
      req_ack[r_grant] = mem_ack;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeout_err;
  logic          w_expire;

  assign timeout_err = r_timeout_err;
  assign w_expire    = (r_cnt == CW'(TIMEOUT - 1));
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= GW'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_state <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
            r_cnt <= '0;
`endif
          end
        end
        ST_BUSY: begin
          // Completion beats both the watchdog and an abort in the same cycle.
          if (mem_ack) begin
            r_last  <= r_grant;
            r_state <= ST_IDLE;
          end else begin
`ifdef ARB_TIMEOUT_EN
            r_cnt <= r_cnt + 1'b1;
            if (w_expire) begin
              r_timeout_err <= 1'b1;
              r_last        <= r_grant;
              r_state       <= ST_IDLE;
            end else if (!req_cs[r_grant]) begin
              r_state <= ST_IDLE;
            end
`else
            if (!req_cs[r_grant]) begin
              r_state <= ST_IDLE;
            end
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter (NUM_REQ=2, TIMEOUT=8)
module tb_mem_arbiter;

  localparam logic [31:0]  A0 = 32'h0000_0040;
  localparam logic [31:0]  A1 = 32'h0000_0080;
  localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
  localparam logic [127:0] D1 = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
  localparam logic [127:0] RD = 128'hCAFE_F00D_0000_1234_5678_9ABC_DEF0_5A5A;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_cs;
  logic [1:0]   req_rw;
  logic [63:0]  req_addr;
  logic [255:0] req_data;
  logic [1:0]   req_ack;
  logic [127:0] req_rdata;
  logic         mem_cs;
  logic         mem_rw;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data;
  logic         mem_ack;
  logic [127:0] mem_rdata;
  logic         grant_id;
  logic         busy;
  logic         timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.NUM_REQ(2), .ADDR_W(32), .BLK_W(128), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_cs     (req_cs),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .req_rdata  (req_rdata),
    .mem_cs     (mem_cs),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0] cs;
    logic       ack;
    logic       e_busy;
    logic       e_gid;
    logic       e_mcs;
    logic [1:0] e_ack;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    logic bad;

    // cs, mem_ack, expected busy, grant_id, mem_cs, req_ack
    tbl[0]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[1]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
    tbl[2]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
    tbl[3]  = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[4]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[5]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[6]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10};
    tbl[7]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[8]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[9]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[10] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10};
    tbl[11] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[12] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[13] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[14] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
    tbl[15] = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[16] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[17] = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00};
    tbl[18] = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10};
    tbl[19] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

    rst       = 1'b1;
    req_cs    = 2'b11;
    req_rw    = 2'b10;
    req_addr  = {A1, A0};
    req_data  = {D1, D0};
    mem_ack   = 1'b1;
    mem_rdata = RD;

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_cs", mem_cs, 1'b0);
    chk("rst_req_ack", req_ack, 2'b00);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_grant", grant_id, 1'b0);

    @(negedge clk);
    rst     = 1'b0;
    req_cs  = 2'b00;
    mem_ack = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_cs  = tbl[i].cs;
      mem_ack = tbl[i].ack;
      #1;
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_mem_cs", i), mem_cs, tbl[i].e_mcs);
      chk($sformatf("v%0d_mem_rw", i), mem_rw, tbl[i].e_busy & tbl[i].e_gid);
      chk($sformatf("v%0d_mem_addr", i), mem_addr,
          tbl[i].e_busy ? (tbl[i].e_gid ? A1 : A0) : 32'h0);
      chk($sformatf("v%0d_mem_data", i), mem_data,
          tbl[i].e_busy ? (tbl[i].e_gid ? D1 : D0) : 128'h0);
      chk($sformatf("v%0d_req_ack", i), req_ack, tbl[i].e_ack);
      chk($sformatf("v%0d_rdata", i), req_rdata, RD);
      chk($sformatf("v%0d_terr", i), timeout_err, 1'b0);
      if (tbl[i].e_busy) chk($sformatf("v%0d_grant", i), grant_id, tbl[i].e_gid);
    end

    // Async reset mid-transaction while requester 0 last won.
    @(negedge clk); req_cs = 2'b01; mem_ack = 1'b0;
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    @(negedge clk); mem_ack = 1'b1;
    #1;
    chk("rstmid_pre_ack", req_ack, 2'b01);
    chk("rstmid_pre_cs", mem_cs, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_mem_cs", mem_cs, 1'b0);
    chk("rstmid_req_ack", req_ack, 2'b00);
    chk("rstmid_busy", busy, 1'b0);
    @(negedge clk); rst = 1'b0; mem_ack = 1'b0; req_cs = 2'b11;
    @(negedge clk);
    #1;
    chk("post_rst_busy", busy, 1'b1);
    chk("post_rst_grant", grant_id, 1'b0);
    chk("post_rst_addr", mem_addr, A0);
    mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0; req_cs = 2'b00;
    @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    req_cs = 2'b01;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (timeout_err) seen = 1'b1;
      else if (busy) n++;
    end
    chk("to_seen", seen, 1'b1);
    chk("to_busy_cycles", n, 8);
    chk("to_mem_cs_dropped", mem_cs, 1'b0);
    @(negedge clk);
    #1;
    chk("to_pulse_width", timeout_err, 1'b0);
    chk("to_regrant", busy, 1'b1);
    for (int k = 2; k <= 8; k++) @(negedge clk);
    mem_ack = 1'b1;
    #1;
    chk("to_ack8_busy", busy, 1'b1);
    chk("to_ack8_req_ack", req_ack, 2'b01);
    @(negedge clk); mem_ack = 1'b0; req_cs = 2'b00;
    #1;
    chk("to_ack8_no_err", timeout_err, 1'b0);
    chk("to_ack8_idle", busy, 1'b0);
`else
    req_cs = 2'b01;
    bad = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (!busy || timeout_err || !mem_cs) bad = 1'b1;
    end
    chk("no_to_waits", bad, 1'b0);
    mem_ack = 1'b1;
    #1;
    chk("no_to_ack", req_ack, 2'b01);
    @(negedge clk); mem_ack = 1'b0; req_cs = 2'b00;
    #1;
    chk("no_to_idle", busy, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
